// File: rtl/counter_seq_ctrl_pkg.sv
// Shared encodings and default sizes for the counter sequencing controller.
package counter_ctrl_pkg;

   localparam int DEF_WIDTH  = 3;
   localparam int DEF_WRAP_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Command/status bundle between the board control logic and the sequencer.
interface counter_seq_ctrl_if
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int WRAP_W = DEF_WRAP_W
);
   logic              start;
   logic              stop;
   logic              pause;
   logic              dir;
   logic [WIDTH-1:0]  load_val;
   logic [WRAP_W-1:0] wrap_target;
   logic [WIDTH-1:0]  q;
   logic              busy;
   logic              wrap;
   logic              done;
   state_t            state;

   modport master (
      output start, stop, pause, dir, load_val, wrap_target,
      input  q, busy, wrap, done, state
   );

   modport slave (
      input  start, stop, pause, dir, load_val, wrap_target,
      output q, busy, wrap, done, state
   );
endinterface

// File: rtl/counter_seq_ctrl_core.sv
// Loadable up/down modulo-2^WIDTH counter; wrap_next flags the step that wraps.
module counter_3_core
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic             dir,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             wrap_next
);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   always_comb begin
      wrap_next = en && ((dir == DIR_UP) ? (q == '1) : (q == '0));
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (en) begin
         q <= (dir == DIR_UP) ? q + ONE : q - ONE;
      end
   end
endmodule

// File: rtl/counter_seq_ctrl.sv
// Run sequencer: load, count, pause/abort and stop after a programmed number of wraps.
module counter_seq_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int WRAP_W = DEF_WRAP_W
) (
   input logic               clk,
   input logic               rst,
   counter_seq_ctrl_if.slave bus
);
   localparam logic [WRAP_W-1:0] CNT_ONE = WRAP_W'(1);
   localparam logic [WRAP_W-1:0] CNT_MAX = '1;

   state_t            state_r;
   logic [WRAP_W-1:0] wrap_cnt;
   logic [WRAP_W-1:0] target_l;
   logic              dir_l;
   logic              wrap_r;
   logic              cnt_load;
   logic              cnt_en;
   logic              wrap_next;
   logic [WIDTH-1:0]  q;

   // stop outranks pause, which outranks start/count
   assign cnt_load = (state_r == ST_IDLE) && bus.start && !bus.stop;
   assign cnt_en   = (state_r == ST_RUN) && !bus.stop && !bus.pause;

   counter_3_core #(.WIDTH(WIDTH)) u_core (
      .clk       (clk),
      .rst       (rst),
      .en        (cnt_en),
      .load      (cnt_load),
      .dir       (dir_l),
      .load_val  (bus.load_val),
      .q         (q),
      .wrap_next (wrap_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         wrap_cnt <= '0;
         target_l <= '0;
         dir_l    <= DIR_UP;
         wrap_r   <= 1'b0;
      end else begin
         wrap_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (cnt_load) begin
                  dir_l    <= bus.dir;
                  target_l <= bus.wrap_target;
                  wrap_cnt <= '0;
                  state_r  <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (bus.stop) begin
                  state_r <= ST_IDLE;
               end else if (bus.pause) begin
                  state_r <= ST_PAUSE;
               end else if (wrap_next) begin
                  wrap_r <= 1'b1;
                  // a zero target means free-run, so the count only saturates
                  if (wrap_cnt != CNT_MAX) wrap_cnt <= wrap_cnt + CNT_ONE;
                  if ((target_l != '0) && (wrap_cnt + CNT_ONE == target_l)) state_r <= ST_DONE;
               end
            end
            ST_PAUSE: begin
               if (bus.stop) state_r <= ST_IDLE;
               else if (!bus.pause) state_r <= ST_RUN;
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   assign bus.q     = q;
   assign bus.state = state_r;
   assign bus.busy  = (state_r == ST_RUN) || (state_r == ST_PAUSE);
   assign bus.done  = (state_r == ST_DONE);
   assign bus.wrap  = wrap_r;
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl: directed runs with hand-derived responses.
module tb_counter_seq_ctrl;
   import counter_ctrl_pkg::*;

   typedef struct {
      string      name;
      logic [7:0] exp;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   counter_seq_ctrl_if #(.WIDTH(3), .WRAP_W(4)) bus ();

   counter_seq_ctrl #(.WIDTH(3), .WRAP_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got q=%0d busy=%b wrap=%b done=%b state=%0d, want q=%0d busy=%b wrap=%b done=%b state=%0d",
                  nm, act[7:5], act[4], act[3], act[2], act[1:0],
                  exp[7:5], exp[4], exp[3], exp[2], exp[1:0]);
      end
   endtask

   function automatic logic [7:0] pack_exp(input int eq, input state_t es, input logic ew, input logic ed);
      logic [2:0] q3;
      q3 = 3'(eq % 8);
      return {q3, (es == ST_RUN) || (es == ST_PAUSE), ew, ed, es};
   endfunction

   function automatic logic [7:0] observed();
      return {bus.q, bus.busy, bus.wrap, bus.done, bus.state};
   endfunction

   // Monitor: compares each queued response one clock after it was issued.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check(e.name, observed(), e.exp);
      end
   end

   // Called just after a falling edge: drive controls, queue the post-edge response.
   task automatic step(input string nm, input logic s_start, input logic s_stop, input logic s_pause,
                       input int eq, input state_t es, input logic ew, input logic ed);
      exp_t e;
      #1;
      bus.start = s_start;
      bus.stop  = s_stop;
      bus.pause = s_pause;
      e.name = nm;
      e.exp  = pack_exp(eq, es, ew, ed);
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic setup(input logic d, input int lv, input int tgt);
      bus.dir         = d;
      bus.load_val    = 3'(lv);
      bus.wrap_target = 4'(tgt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.pause = 1'b0;
      setup(DIR_UP, 0, 0);
      repeat (2) @(negedge clk);
      check("reset_init", observed(), pack_exp(0, ST_IDLE, 1'b0, 1'b0));
      rst = 1'b0;
      @(negedge clk);

      // Up run: 5 -> ... two wraps, done on the 11th edge
      setup(DIR_UP, 5, 2);
      step("up_load", 1, 0, 0, 5, ST_RUN, 0, 0);
      for (int i = 1; i <= 11; i++)
         step($sformatf("up[%0d]", i), 0, 0, 0, 5 + i, (i == 11) ? ST_DONE : ST_RUN,
              (i == 3) || (i == 11), i == 11);
      step("up_done_start_ignored", 1, 0, 0, 0, ST_IDLE, 0, 0);
      step("up_idle", 0, 0, 0, 0, ST_IDLE, 0, 0);

      // Down run: 1, 0, 7 with wrap and done together
      setup(DIR_DOWN, 1, 1);
      step("dn_load", 1, 0, 0, 1, ST_RUN, 0, 0);
      step("dn[1]", 0, 0, 0, 0, ST_RUN, 0, 0);
      step("dn[2]", 0, 0, 0, 7, ST_DONE, 1, 1);
      step("dn_idle", 0, 0, 0, 7, ST_IDLE, 0, 0);

      // Pause at q=3 for 4 cycles; the wrap count survives the pause
      setup(DIR_UP, 6, 2);
      step("pz_load", 1, 0, 0, 6, ST_RUN, 0, 0);
      step("pz[1]", 0, 0, 0, 7, ST_RUN, 0, 0);
      step("pz[2]", 0, 0, 0, 0, ST_RUN, 1, 0);
      for (int i = 1; i <= 3; i++)
         step($sformatf("pz_run[%0d]", i), 0, 0, 0, i, ST_RUN, 0, 0);
      for (int i = 0; i < 4; i++)
         step($sformatf("pz_hold[%0d]", i), 0, 0, 1, 3, ST_PAUSE, 0, 0);
      step("pz_release", 0, 0, 0, 3, ST_RUN, 0, 0);
      for (int i = 4; i <= 7; i++)
         step($sformatf("pz_resume[%0d]", i), 0, 0, 0, i, ST_RUN, 0, 0);
      step("pz_done", 0, 0, 0, 0, ST_DONE, 1, 1);
      step("pz_idle", 0, 0, 0, 0, ST_IDLE, 0, 0);

      // Abort at q=6, then start+stop together in IDLE
      setup(DIR_UP, 3, 0);
      step("ab_load", 1, 0, 0, 3, ST_RUN, 0, 0);
      for (int i = 4; i <= 6; i++)
         step($sformatf("ab_run[%0d]", i), 0, 0, 0, i, ST_RUN, 0, 0);
      step("ab_stop", 0, 1, 0, 6, ST_IDLE, 0, 0);
      step("ab_idle", 0, 0, 0, 6, ST_IDLE, 0, 0);
      setup(DIR_UP, 2, 1);
      step("ab_start_stop", 1, 1, 0, 6, ST_IDLE, 0, 0);
      step("ab_after", 0, 0, 0, 6, ST_IDLE, 0, 0);

      // Free run, target 0: wrap every 8 edges, starts ignored
      setup(DIR_UP, 0, 0);
      step("fr_load", 1, 0, 0, 0, ST_RUN, 0, 0);
      bus.load_val = 3'd5;
      for (int i = 1; i <= 40; i++)
         step($sformatf("fr[%0d]", i), (i % 7) == 3, 0, 0, i, ST_RUN, (i % 8) == 0, 0);
      step("fr_stop", 0, 1, 0, 0, ST_IDLE, 0, 0);

      // Mid-run asynchronous reset held 25 ns
      setup(DIR_UP, 4, 3);
      step("rs_load", 1, 0, 0, 4, ST_RUN, 0, 0);
      step("rs[1]", 0, 0, 0, 5, ST_RUN, 0, 0);
      step("rs[2]", 0, 0, 0, 6, ST_RUN, 0, 0);
      #3 rst = 1'b1;
      #1 check("rst_immediate", observed(), pack_exp(0, ST_IDLE, 0, 0));
      #10 check("rst_hold1", observed(), pack_exp(0, ST_IDLE, 0, 0));
      #10 check("rst_hold2", observed(), pack_exp(0, ST_IDLE, 0, 0));
      #4 rst = 1'b0;
      @(negedge clk);
      step("rs_after[1]", 0, 0, 0, 0, ST_IDLE, 0, 0);
      step("rs_after[2]", 0, 0, 0, 0, ST_IDLE, 0, 0);

      repeat (2) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
